// File: rtl/remote_cmd_seq_pkg.sv
// Shared types and constants for the remote_cmd_seq bench-side command sequencer.
package remote_cmd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_SENT,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_NAK  = 2'b01,
        ERR_TMO  = 2'b10
    } err_code_e;

    localparam logic [7:0] DEFAULT_ACK = 8'hA5;

    // Knight command opcodes, carried in the top nibble of a command word
    localparam logic [3:0] CMD_CAL  = 4'h2;
    localparam logic [3:0] CMD_MOVE = 4'h4;
    localparam logic [3:0] CMD_TOUR = 4'h6;

endpackage

// File: rtl/remote_cmd_seq_fifo.sv
// Synchronous command FIFO with flush; a push into a full queue succeeds only
// when a pop happens in the same cycle.
module remote_cmd_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             pushOk;
    logic             popOk;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign pushOk = push && (!full || pop);
    assign popOk  = pop && !empty;
    assign dout   = mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
            if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
            if (pushOk && !popOk)      count_q <= count_q + (AW+1)'(1);
            else if (popOk && !pushOk) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage needs no reset; a flush or reset just rewinds the pointers
    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= din;
    end

endmodule

// File: rtl/remote_cmd_seq.sv
// Queues Knight commands and plays them out on remoteComm's cmd/send_cmd handshake,
// checking each response byte. Define REMOTE_CMD_SEQ_RETRY_EN for one retry per command.
module remote_cmd_seq
    import remote_cmd_seq_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         TIMEOUT_CYC = 8000000,
    parameter logic [7:0] ACK         = DEFAULT_ACK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [15:0]            push_cmd,
    output logic                   full,
    input  logic                   go,
    input  logic                   abort,
    output logic [15:0]            cmd,
    output logic                   send_cmd,
    input  logic                   cmd_sent,
    input  logic                   resp_rdy,
    input  logic [7:0]             resp,
    output logic                   busy,
    output logic                   seq_done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [$clog2(DEPTH):0] num_done
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    ,
    output logic [7:0]             retry_cnt
`endif
);

    localparam int NUM_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             sendCmd_q, sendCmd_d;
    logic [NUM_W-1:0] numDone_q, numDone_d;
    logic             err_q, err_d;
    err_code_e        errCode_q, errCode_d;
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
    logic             fifoPush, fifoPop, fifoFlush, fifoFull, fifoEmpty;
    logic [15:0]      fifoHead;
    logic             fail;
    err_code_e        failCode;
    logic             reissue;

`ifdef REMOTE_CMD_SEQ_RETRY_EN
    logic       retry_q, retry_d;
    logic [7:0] retryCnt_q, retryCnt_d;
    assign reissue   = retry_q;
    assign retry_cnt = retryCnt_q;
`else
    assign reissue   = 1'b0;
`endif

    remote_cmd_seq_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .flush (fifoFlush),
        .din   (push_cmd),
        .dout  (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign full     = fifoFull;
    assign cmd      = cmd_q;
    assign send_cmd = sendCmd_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign seq_done = (state_q == ST_DONE);
    assign err      = err_q;
    assign err_code = errCode_q;
    assign num_done = numDone_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            sendCmd_q <= 1'b0;
            numDone_q <= '0;
            err_q     <= 1'b0;
            errCode_q <= ERR_NONE;
            tmoCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            sendCmd_q <= sendCmd_d;
            numDone_q <= numDone_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
            tmoCnt_q  <= tmoCnt_d;
        end
    end

`ifdef REMOTE_CMD_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q    <= 1'b0;
            retryCnt_q <= '0;
        end else begin
            retry_q    <= retry_d;
            retryCnt_q <= retryCnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        sendCmd_d = 1'b0;
        numDone_d = numDone_q;
        err_d     = err_q;
        errCode_d = errCode_q;
        tmoCnt_d  = tmoCnt_q;
        fifoPush  = push && (state_q != ST_ERR);
        fifoPop   = 1'b0;
        fifoFlush = 1'b0;
        fail      = 1'b0;
        failCode  = ERR_NONE;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
        retry_d    = retry_q;
        retryCnt_d = retryCnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    numDone_d = '0;
                    state_d   = fifoEmpty ? ST_DONE : ST_ISSUE;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                    retry_d    = 1'b0;
                    retryCnt_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (!reissue) begin
                    fifoPop = 1'b1;
                    cmd_d   = fifoHead;
                end
                sendCmd_d = 1'b1;
                tmoCnt_d  = '0;
                state_d   = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                tmoCnt_d = tmoCnt_q + TMO_W'(1);
                if (tmoCnt_q == TMO_LAST) begin
                    fail     = 1'b1;
                    failCode = ERR_TMO;
                end else if (cmd_sent) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                tmoCnt_d = tmoCnt_q + TMO_W'(1);
                // A response landing on the expiry cycle takes precedence over the timeout
                if (resp_rdy && (resp == ACK)) begin
                    numDone_d = numDone_q + NUM_W'(1);
                    state_d   = fifoEmpty ? ST_DONE : ST_ISSUE;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                end else if (resp_rdy) begin
                    fail     = 1'b1;
                    failCode = ERR_NAK;
                end else if (tmoCnt_q == TMO_LAST) begin
                    fail     = 1'b1;
                    failCode = ERR_TMO;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: begin
                if (go) begin
                    err_d     = 1'b0;
                    errCode_d = ERR_NONE;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
`ifdef REMOTE_CMD_SEQ_RETRY_EN
            if (!retry_q) begin
                state_d = ST_ISSUE;
                retry_d = 1'b1;
                if (retryCnt_q != 8'hFF) retryCnt_d = retryCnt_q + 8'd1;
            end else
`endif
            begin
                state_d   = ST_ERR;
                err_d     = 1'b1;
                errCode_d = failCode;
                fifoFlush = 1'b1;
            end
        end

        // abort overrides everything decided above except an already-registered send_cmd
        if (abort) begin
            state_d   = ST_IDLE;
            fifoFlush = 1'b1;
            fifoPush  = 1'b0;
            fifoPop   = 1'b0;
            sendCmd_d = 1'b0;
            cmd_d     = cmd_q;
            numDone_d = numDone_q;
            err_d     = err_q;
            errCode_d = errCode_q;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
            retry_d    = 1'b0;
            retryCnt_d = retryCnt_q;
`endif
        end
    end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Randomized self-checking bench for remote_cmd_seq; plays the remoteComm side and
// predicts every issued command and sequence outcome from a queue-level model.
module tb_remote_cmd_seq;
    import remote_cmd_seq_pkg::*;

    localparam int         DEPTH       = 8;
    localparam int         TIMEOUT_CYC = 1000;
    localparam logic [7:0] ACKV        = 8'hA5;
    localparam int K_ACK    = 0;
    localparam int K_NAK    = 1;
    localparam int K_TMO    = 2;
    localparam int K_ACKEXP = 3;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] push_cmd;
    logic        full;
    logic        go;
    logic        abort;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        seq_done;
    logic        err;
    logic [1:0]  err_code;
    logic [3:0]  num_done;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    logic [7:0]  retry_cnt;
`endif

    int          checkCount;
    int          passCount;
    logic [15:0] modelQ[$];
    logic [15:0] cur;
    int          expDone;
    int          expRetry;
    bit          retried;

    remote_cmd_seq #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ACK         (ACKV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_cmd (push_cmd),
        .full     (full),
        .go       (go),
        .abort    (abort),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .seq_done (seq_done),
        .err      (err),
        .err_code (err_code),
        .num_done (num_done)
`ifdef REMOTE_CMD_SEQ_RETRY_EN
        ,
        .retry_cnt (retry_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic logic [15:0] randCmd();
        logic [3:0] op;
        case ($urandom_range(2))
            0:       op = CMD_CAL;
            1:       op = CMD_MOVE;
            default: op = CMD_TOUR;
        endcase
        return {op, 12'($urandom_range(4095))};
    endfunction

    function automatic logic [7:0] nakByte();
        logic [7:0] r;
        do r = 8'($urandom); while (r == ACKV);
        return r;
    endfunction

    function automatic int pickKind(input int kind);
        int r;
        if (kind >= 0) return kind;
        r = $urandom_range(99);
        if (r < 5)  return K_NAK;
        if (r < 8)  return K_TMO;
        if (r < 11) return K_ACKEXP;
        return K_ACK;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, " cmd"}, cmd, 0);
        checkOutput({tag, " send_cmd"}, send_cmd, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " seq_done"}, seq_done, 0);
        checkOutput({tag, " err"}, err, 0);
        checkOutput({tag, " err_code"}, err_code, 0);
        checkOutput({tag, " num_done"}, num_done, 0);
        checkOutput({tag, " full"}, full, 0);
`ifdef REMOTE_CMD_SEQ_RETRY_EN
        checkOutput({tag, " retry_cnt"}, retry_cnt, 0);
`endif
    endtask

    task automatic pushCmd(input logic [15:0] c);
        push = 1'b1;
        push_cmd = c;
        tick();
        push = 1'b0;
        if (modelQ.size() < DEPTH) modelQ.push_back(c);
        checkOutput("full after push", full, modelQ.size() == DEPTH);
    endtask

    // Plays one remoteComm transaction, starting in the cycle send_cmd is seen high.
    // Ends in the cycle after the response edge (or after the expiry edge).
    task automatic serveAttempt(input int kind);
        int since;
        int d1;
        int d2;
        bit sendIt;
        since  = 0;
        d1     = $urandom_range(1, 30);
        d2     = $urandom_range(0, 60);
        sendIt = (kind != K_TMO) || ($urandom_range(1) == 1);
        tick(); since++;
        checkOutput("send_cmd one cycle", send_cmd, 0);
        for (int i = 1; i < d1; i++) begin
            if (i == 1 && $urandom_range(1) == 1) begin
                resp_rdy = 1'b1;
                resp = ACKV;
                go = 1'b1;
            end
            tick(); since++;
            resp_rdy = 1'b0;
            go = 1'b0;
        end
        if (sendIt) begin
            cmd_sent = 1'b1;
            tick(); since++;
            cmd_sent = 1'b0;
        end
        if (kind == K_ACK || kind == K_NAK) begin
            repeat (d2) begin tick(); since++; end
            resp_rdy = 1'b1;
            resp = (kind == K_ACK) ? ACKV : nakByte();
            tick();
            resp_rdy = 1'b0;
        end else begin
            while (since < TIMEOUT_CYC - 1) begin tick(); since++; end
            checkOutput("busy on expiry cycle", busy, 1);
            if (kind == K_ACKEXP) begin
                resp_rdy = 1'b1;
                resp = ACKV;
            end
            tick();
            resp_rdy = 1'b0;
        end
    endtask

    // Pushes nPush random commands on top of anything already queued, starts the
    // sequence and follows it to seq_done or ERR, checking against the model.
    task automatic applyStimulus(input int nPush, input bit pushAtIssue, input int kind);
        int k;
        logic [15:0] extra;
        for (int i = 0; i < nPush; i++) pushCmd(randCmd());
        expDone = 0;
        expRetry = 0;
        retried = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        if (modelQ.size() == 0) begin
            checkOutput("empty go seq_done", seq_done, 1);
            checkOutput("empty go num_done", num_done, 0);
            tick();
            checkOutput("empty go idle", busy, 0);
            return;
        end
        extra = randCmd();
        if (pushAtIssue) begin
            push = 1'b1;
            push_cmd = extra;
        end
        tick();
        push = 1'b0;
        cur = modelQ.pop_front();
        if (pushAtIssue) modelQ.push_back(extra);
        checkOutput("full after issue", full, modelQ.size() == DEPTH);
        forever begin
            checkOutput("send_cmd", send_cmd, 1);
            checkOutput("cmd", cmd, cur);
            checkOutput("busy", busy, 1);
            k = pickKind(kind);
            serveAttempt(k);
            if (k == K_ACK || k == K_ACKEXP) begin
                expDone++;
                retried = 1'b0;
                checkOutput("num_done", num_done, expDone);
                if (modelQ.size() == 0) begin
                    checkOutput("seq_done", seq_done, 1);
                    checkOutput("err at done", err, 0);
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                    checkOutput("retry_cnt at done", retry_cnt, expRetry);
`endif
                    tick();
                    checkOutput("seq_done pulse", seq_done, 0);
                    checkOutput("idle after done", busy, 0);
                    return;
                end
                checkOutput("no early seq_done", seq_done, 0);
                tick();
                cur = modelQ.pop_front();
            end else if (RETRY_EN && !retried) begin
                retried = 1'b1;
                expRetry++;
                tick();
`ifdef REMOTE_CMD_SEQ_RETRY_EN
                checkOutput("retry_cnt", retry_cnt, expRetry);
`endif
            end else begin
                checkOutput("err", err, 1);
                checkOutput("err_code", err_code, (k == K_NAK) ? 1 : 2);
                checkOutput("busy in err", busy, 0);
                checkOutput("no seq_done on err", seq_done, 0);
                checkOutput("num_done at err", num_done, expDone);
                checkOutput("full flushed", full, 0);
                modelQ.delete();
                go = 1'b1;
                push = 1'b1;
                push_cmd = randCmd();
                tick();
                go = 1'b0;
                push = 1'b0;
                checkOutput("err cleared", err, 0);
                checkOutput("err_code cleared", err_code, 0);
                checkOutput("go in err no start", busy, 0);
                go = 1'b1;
                tick();
                go = 1'b0;
                checkOutput("queue flushed on err", seq_done, 1);
                tick();
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0;
        push_cmd = '0;
        go = 1'b0;
        abort = 1'b0;
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        resp = '0;
        checkCount = 0;
        passCount = 0;
        repeat (3) tick();
        checkReset("reset");
        rst = 1'b0;
        tick();
        checkReset("idle");

        pushCmd(16'h2000);
        applyStimulus(0, 1'b0, K_ACK);
        pushCmd(16'h2000);
        pushCmd(16'h4001);
        pushCmd(16'h6022);
        applyStimulus(0, 1'b0, K_ACK);
        pushCmd(16'h4001);
        applyStimulus(0, 1'b0, K_NAK);
        pushCmd(16'h2000);
        applyStimulus(0, 1'b0, K_TMO);
        pushCmd(16'h4001);
        applyStimulus(0, 1'b0, K_ACKEXP);
        applyStimulus(9, 1'b0, K_ACK);
        applyStimulus(8, 1'b1, K_ACK);
        applyStimulus(0, 1'b0, K_ACK);

        // abort in WAIT_RESP, together with go and push that must lose
        for (int i = 0; i < 3; i++) pushCmd(randCmd());
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        checkOutput("abort: send_cmd", send_cmd, 1);
        tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        abort = 1'b1;
        go = 1'b1;
        push = 1'b1;
        push_cmd = randCmd();
        tick();
        abort = 1'b0;
        go = 1'b0;
        push = 1'b0;
        modelQ.delete();
        checkOutput("abort: busy", busy, 0);
        checkOutput("abort: seq_done", seq_done, 0);
        checkOutput("abort: full", full, 0);
        checkOutput("abort: err", err, 0);
        tick();
        checkOutput("abort: no late seq_done", seq_done, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        checkOutput("abort: queue empty", seq_done, 1);
        checkOutput("abort: num_done", num_done, 0);
        tick();

        // reset while the second command waits for cmd_sent
        pushCmd(16'h2000);
        pushCmd(16'h4001);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        cur = modelQ.pop_front();
        checkOutput("rst: first cmd", cmd, cur);
        serveAttempt(K_ACK);
        tick();
        cur = modelQ.pop_front();
        checkOutput("rst: second cmd", cmd, cur);
        tick();
        checkOutput("rst: num_done before", num_done, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelQ.delete();
        checkReset("mid-op reset");
        go = 1'b1;
        tick();
        go = 1'b0;
        checkOutput("rst: queue empty", seq_done, 1);
        tick();

        for (int n = 0; n < 25; n++)
            applyStimulus($urandom_range(1, DEPTH + 1), 1'($urandom_range(1)), -1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
